// File: rtl/rng_pkg.sv
// Shared constants for the combined LFSR/CASR pseudo-random generator.
// Widths, feedback taps, the hybrid rule-150 cell and the reset image live here.
package rng_pkg;

    localparam int LFSR_W = 43;
    localparam int CASR_W = 37;
    localparam int OUT_W  = 32;

    localparam int LFSR_TAP_A = 42;
    localparam int LFSR_TAP_B = 40;
    localparam int LFSR_TAP_C = 19;
    localparam int LFSR_TAP_D = 0;

    // The single cell that uses rule 150 instead of rule 90; this makes the
    // 90/150 hybrid automaton maximal-length on a cyclic 37-cell ring.
    localparam int CASR_R150_IDX = 27;

    localparam logic [LFSR_W-1:0] LFSR_RST = LFSR_W'(1);
    localparam logic [CASR_W-1:0] CASR_RST = CASR_W'(1);

    // Selects what the registers take on the next clock edge.
    typedef enum logic [1:0] {
        UPD_STEP   = 2'd0,
        UPD_SEED   = 2'd1,
        UPD_RESEED = 2'd2
    } upd_e;

endpackage

// File: rtl/rng_casr_step.sv
// One combinational step of the 37-cell cyclic cellular automaton:
// rule 90 everywhere except one rule-150 cell.
module rng_casr_step
    import rng_pkg::*;
(
    input  logic [CASR_W-1:0] casr_i,
    output logic [CASR_W-1:0] casr_next_o
);

    for (genvar g = 0; g < CASR_W; g++) begin : g_cell
        localparam int LEFT  = (g + CASR_W - 1) % CASR_W;
        localparam int RIGHT = (g + 1) % CASR_W;
        if (g == CASR_R150_IDX) begin : g_r150
            assign casr_next_o[g] = casr_i[LEFT] ^ casr_i[g] ^ casr_i[RIGHT];
        end else begin : g_r90
            assign casr_next_o[g] = casr_i[LEFT] ^ casr_i[RIGHT];
        end
    end

endmodule

// File: rtl/rng.sv
// Pseudo-random word source: a 43-bit LFSR XORed with a 37-bit hybrid CASR.
// A zero seed reloads the reset image so neither register can lock up at zero.
module rng
    import rng_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loadseed_i,
    input  logic [31:0]      seed_i,
    output logic [OUT_W-1:0] number_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [CASR_W-1:0] casr_q;
    logic [CASR_W-1:0] casr_d;
    logic [CASR_W-1:0] casr_step;
    logic              lfsr_fb;
    upd_e              upd;

    assign lfsr_fb = lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]
                   ^ lfsr_q[LFSR_TAP_C] ^ lfsr_q[LFSR_TAP_D];

    rng_casr_step u_casr_step (
        .casr_i      (casr_q),
        .casr_next_o (casr_step)
    );

    // Loading always wins over stepping.
    always_comb begin
        upd = UPD_STEP;
        if (loadseed_i) begin
            upd = (seed_i != '0) ? UPD_SEED : UPD_RESEED;
        end
    end

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
        casr_d = casr_step;
        case (upd)
            UPD_SEED: begin
                lfsr_d = {{(LFSR_W-32){1'b0}}, seed_i};
                casr_d = {{(CASR_W-32){1'b0}}, seed_i};
            end
            UPD_RESEED: begin
                lfsr_d = LFSR_RST;
                casr_d = CASR_RST;
            end
            default: begin
                lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
                casr_d = casr_step;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_RST;
            casr_q <= CASR_RST;
        end else begin
            lfsr_q <= lfsr_d;
            casr_q <= casr_d;
        end
    end

    assign number_o = lfsr_q[OUT_W-1:0] ^ casr_q[OUT_W-1:0];

endmodule

// File: tb/tb_rng.sv
// Bench for rng: directed vectors plus a reference-model run, checked by a
// scoreboard whose monitor pops one expected word after every clock edge.
module tb_rng;

    logic        clk;
    logic        rst_n;
    logic        loadseed_i;
    logic [31:0] seed_i;
    logic [31:0] number_o;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;

    logic [42:0] m_lfsr;
    logic [36:0] m_casr;

    localparam logic [42:0] TAP_MASK = 43'h50000080001;

    rng dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loadseed_i (loadseed_i),
        .seed_i     (seed_i),
        .number_o   (number_o)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // reference model, written as ring rotations rather than per-cell terms
    task automatic model_step();
        logic        fb;
        logic [36:0] rl;
        logic [36:0] rr;
        logic [36:0] nc;
        fb     = ^(m_lfsr & TAP_MASK);
        m_lfsr = {m_lfsr[41:0], fb};
        rl     = {m_casr[35:0], m_casr[36]};
        rr     = {m_casr[0], m_casr[36:1]};
        nc     = rl ^ rr;
        nc[27] = nc[27] ^ m_casr[27];
        m_casr = nc;
    endtask

    task automatic model_load(input logic [31:0] sd);
        if (sd != 32'h0) begin
            m_lfsr = {11'b0, sd};
            m_casr = {5'b0, sd};
        end else begin
            m_lfsr = 43'h1;
            m_casr = 37'h1;
        end
    endtask

    // driver: applies inputs for the coming edge and records its expected result
    task automatic drive(input logic ld, input logic [31:0] sd,
                         input logic [31:0] exp, input string nm);
        loadseed_i = ld;
        seed_i     = sd;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic mdrive(input logic ld, input logic [31:0] sd);
        if (ld) model_load(sd);
        else    model_step();
        drive(ld, sd, m_lfsr[31:0] ^ m_casr[31:0], ld ? "model_load" : "model_step");
    endtask

    // monitor: one word per clock edge, compared against the scoreboard head
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, number_o, e);
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        loadseed_i = 1'b0;
        seed_i     = 32'h0;
        #2;
        check("reset_level", number_o, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        drive(1'b0, 32'h0, 32'h00000001, "step1");
        drive(1'b0, 32'h0, 32'h00000003, "step2");

        drive(1'b1, 32'h00000007, 32'h0, "seed7_load");
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h00000007, 32'h0, "seed7_hold");
        drive(1'b0, 32'h0, 32'h00000002, "seed7_step");
        drive(1'b1, 32'hDEADBEEF, 32'h0, "seed_dead");
        drive(1'b1, 32'h0, 32'h0, "seed_zero");
        drive(1'b0, 32'h0, 32'h00000001, "seed_zero_step1");
        drive(1'b0, 32'h0, 32'h00000003, "seed_zero_step2");

        mdrive(1'b1, 32'h12345678);
        for (int i = 0; i < 3000; i++) begin
            logic        ld;
            logic [31:0] sd;
            ld = ($urandom_range(0, 49) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            mdrive(ld, sd);
        end

        mdrive(1'b1, 32'h0);
        for (int i = 0; i < 50; i++) mdrive(1'b0, 32'h0);

        // reset mid-cycle with a load pending; both must be discarded
        loadseed_i = 1'b1;
        seed_i     = 32'h00001234;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async", number_o, 32'h0);
        @(posedge clk);
        #1;
        check("reset_held_edge", number_o, 32'h0);
        #1;
        loadseed_i = 1'b0;
        seed_i     = 32'h0;
        rst_n      = 1'b1;
        drive(1'b0, 32'h0, 32'h00000001, "post_rst_step1");
        drive(1'b0, 32'h0, 32'h00000003, "post_rst_step2");

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
